// File: rtl/multi_port_param_memory.sv
// Multi-channel burst memory model: round-robin arbitration over one shared line store,
// open-row latency modelling, address wrap-around and sticky protocol-error flagging.
module multi_port_param_memory #(
   parameter int unsigned NCH         = 2,
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned BURST_LEN   = 4,
   parameter int unsigned DEPTH_LINES = 1024,
   parameter int unsigned PAGE_BITS   = 12,
   parameter int unsigned MISS_CYCLES = 50,
   parameter int unsigned HIT_CYCLES  = 25
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NCH-1:0]          mem_read,
   input  logic [NCH-1:0]          mem_write,
   input  logic [NCH*32-1:0]       mem_addr,
   input  logic [NCH*DATA_W-1:0]   mem_wdata,
   output logic [DATA_W-1:0]       mem_rdata,
   output logic [NCH-1:0]          mem_resp,
   output logic                    busy,
   output logic                    err
);

   localparam int unsigned LINE_W     = DATA_W * BURST_LEN;
   localparam int unsigned LINE_BYTES = DATA_W / 8 * BURST_LEN;
   localparam int unsigned OFF_BITS   = $clog2(LINE_BYTES);
   localparam int unsigned IDX_W      = $clog2(DEPTH_LINES);
   localparam int unsigned ROW_W      = 32 - PAGE_BITS;
   localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int unsigned CNT_W      = $clog2(MISS_CYCLES + 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StWait  = 2'd1;
   localparam logic [1:0] StBurst = 2'd2;
   localparam logic [1:0] StTurn  = 2'd3;

   logic [31:0]        addr_ch  [NCH];
   logic [DATA_W-1:0]  wdata_ch [NCH];

   for (genvar g = 0; g < NCH; g++) begin : g_unpack
      assign addr_ch[g]  = mem_addr[32*g +: 32];
      assign wdata_ch[g] = mem_wdata[DATA_W*g +: DATA_W];
   end

   // Storage starts zeroed and is deliberately untouched by rst.
   logic [LINE_W-1:0] store_q [DEPTH_LINES] = '{default: '0};

   logic [1:0]        state_q, state_d;
   logic [CH_W-1:0]   ch_q, ch_d;
   logic [CH_W-1:0]   rr_q, rr_d;
   logic              is_read_q, is_read_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [ROW_W-1:0]  open_row_q, open_row_d;
   logic              row_valid_q, row_valid_d;
   logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              err_q, err_d;
   logic              wr_en;

   logic [NCH-1:0]    req;
   logic              req_held;
   logic              gnt_found;
   logic [CH_W-1:0]   gnt_ch;
   logic [CH_W-1:0]   cand;
   logic [31:0]       gnt_addr;
   logic [ROW_W-1:0]  gnt_row;
   logic [IDX_W-1:0]  gnt_idx;
   logic              row_hit;
   logic              unused_addr_bits;
   int unsigned       beat_off;
   logic [LINE_W-1:0] line_rd;
   logic [DATA_W-1:0] beat_rd;

   assign req      = mem_read | mem_write;
   assign req_held = req[ch_q];

   // Round-robin search starting one past the last granted channel.
   always_comb begin
      gnt_found = 1'b0;
      gnt_ch    = rr_q;
      cand      = '0;
      for (int unsigned i = 1; i <= NCH; i++) begin
         cand = CH_W'((32'(rr_q) + i) % NCH);
         if (!gnt_found && req[cand]) begin
            gnt_found = 1'b1;
            gnt_ch    = cand;
         end
      end
   end

   assign gnt_addr         = addr_ch[gnt_ch];
   assign gnt_row          = gnt_addr[31:PAGE_BITS];
   assign gnt_idx          = gnt_addr[OFF_BITS +: IDX_W];
   assign row_hit          = row_valid_q && (open_row_q == gnt_row);
   assign unused_addr_bits = ^gnt_addr[OFF_BITS-1:0];

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      rr_d        = rr_q;
      is_read_d   = is_read_q;
      idx_d       = idx_q;
      open_row_d  = open_row_q;
      row_valid_d = row_valid_q;
      wait_cnt_d  = wait_cnt_q;
      beat_d      = beat_q;
      err_d       = err_q;
      wr_en       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               ch_d        = gnt_ch;
               rr_d        = gnt_ch;
               is_read_d   = mem_read[gnt_ch];
               idx_d       = gnt_idx;
               open_row_d  = gnt_row;
               row_valid_d = 1'b1;
               wait_cnt_d  = row_hit ? CNT_W'(HIT_CYCLES) : CNT_W'(MISS_CYCLES);
               beat_d      = '0;
               if (mem_read[gnt_ch] && mem_write[gnt_ch]) begin
                  err_d = 1'b1;
               end
               state_d = StWait;
            end
         end
         StWait: begin
            if (!req_held) begin
               err_d   = 1'b1;
               state_d = StTurn;
            end else if (wait_cnt_q == CNT_W'(1)) begin
               state_d = StBurst;
            end else begin
               wait_cnt_d = wait_cnt_q - CNT_W'(1);
            end
         end
         StBurst: begin
            if (!req_held) begin
               err_d   = 1'b1;
               state_d = StTurn;
            end else begin
               wr_en = !is_read_q;
               if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                  state_d = StTurn;
               end else begin
                  beat_d = beat_q + BEAT_W'(1);
               end
            end
         end
         StTurn:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ch_q        <= '0;
         rr_q        <= CH_W'(NCH - 1);
         is_read_q   <= 1'b0;
         idx_q       <= '0;
         open_row_q  <= '0;
         row_valid_q <= 1'b0;
         wait_cnt_q  <= '0;
         beat_q      <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         rr_q        <= rr_d;
         is_read_q   <= is_read_d;
         idx_q       <= idx_d;
         open_row_q  <= open_row_d;
         row_valid_q <= row_valid_d;
         wait_cnt_q  <= wait_cnt_d;
         beat_q      <= beat_d;
         err_q       <= err_d;
      end
   end

   assign beat_off = 32'(beat_q) * DATA_W;

   // A write beat lands at the edge closing its beat cycle unless rst wins that edge.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         store_q[idx_q][beat_off +: DATA_W] <= wdata_ch[ch_q];
      end
   end

   assign line_rd = store_q[idx_q];
   assign beat_rd = line_rd[beat_off +: DATA_W];

   always_comb begin
      mem_resp  = '0;
      mem_rdata = '0;
      if (state_q == StBurst && req_held) begin
         mem_resp[ch_q] = 1'b1;
         if (is_read_q) begin
            mem_rdata = beat_rd;
         end
      end
   end

   assign busy = (state_q != StIdle);
   assign err  = err_q;

endmodule

// File: tb/tb_multi_port_param_memory.sv
// Self-checking bench: directed scenarios plus random traffic against a line/row-level model.
module tb_multi_port_param_memory;

   localparam int NCH   = 2;
   localparam int DW    = 64;
   localparam int BL    = 4;
   localparam int DEPTH = 1024;
   localparam int PB    = 12;
   localparam int MISS  = 50;
   localparam int HIT   = 25;
   localparam int LB    = DW / 8 * BL;

   logic                clk = 1'b0;
   logic                rst;
   logic [NCH-1:0]      mem_read;
   logic [NCH-1:0]      mem_write;
   logic [NCH*32-1:0]   mem_addr;
   logic [NCH*DW-1:0]   mem_wdata;
   logic [DW-1:0]       mem_rdata;
   logic [NCH-1:0]      mem_resp;
   logic                busy;
   logic                err;

   multi_port_param_memory #(
      .NCH(NCH), .DATA_W(DW), .BURST_LEN(BL), .DEPTH_LINES(DEPTH),
      .PAGE_BITS(PB), .MISS_CYCLES(MISS), .HIT_CYCLES(HIT)
   ) dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_resp(mem_resp), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: beats per line, open row, RR pointer, sticky error.
   logic [DW-1:0] mdl [DEPTH][BL];
   bit            row_v;
   int unsigned   open_row;
   int            rr;
   bit            err_m;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned line_of(input logic [31:0] a);
      return (a / LB) % DEPTH;
   endfunction

   function automatic int unsigned row_of(input logic [31:0] a);
      return a / (2 ** PB);
   endfunction

   function automatic int model_grant(input int ch, input logic [31:0] a);
      int unsigned r;
      int lat;
      r        = row_of(a);
      lat      = (row_v && open_row == r) ? HIT : MISS;
      open_row = r;
      row_v    = 1'b1;
      rr       = ch;
      return lat;
   endfunction

   function automatic int pick(input logic [NCH-1:0] m);
      for (int i = 1; i <= NCH; i++) begin
         if (m[(rr + i) % NCH]) return (rr + i) % NCH;
      end
      return 0;
   endfunction

   function automatic logic [DW*BL-1:0] rand_line();
      logic [DW*BL-1:0] r;
      for (int i = 0; i < DW * BL / 32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   task automatic set_req(input int ch, input bit rd, input bit wr, input logic [31:0] addr);
      mem_read[ch]         = rd;
      mem_write[ch]        = wr;
      mem_addr[32*ch +: 32] = addr;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst      = 1'b0;
      row_v    = 1'b0;
      rr       = NCH - 1;
      err_m    = 1'b0;
   endtask

   // Wait for the first beat (exp_n negedges from the call), then check every beat.
   task automatic serve(input string tag, input int ch, input int unsigned line, input bit rd,
                        input logic [DW*BL-1:0] wline, input int exp_n);
      int n;
      bit got;
      logic [NCH-1:0] one;
      one      = '0;
      one[ch]  = 1'b1;
      n        = 0;
      got      = 1'b0;
      while (!got && n < 400) begin
         @(negedge clk);
         if (mem_resp[ch]) begin
            got = 1'b1;
         end else begin
            if (n == exp_n - 1) begin
               check({tag, "_wait_resp"}, 64'(mem_resp), 64'd0);
               check({tag, "_wait_busy"}, 64'(busy), 64'd1);
               check({tag, "_wait_rdata"}, 64'(mem_rdata), 64'd0);
               check({tag, "_wait_err"}, 64'(err), 64'(err_m));
            end
            n++;
         end
      end
      check({tag, "_got_resp"}, 64'(got), 64'd1);
      if (!got) return;
      check({tag, "_latency"}, 64'(n), 64'(exp_n));
      for (int k = 0; k < BL; k++) begin
         if (k > 0) @(negedge clk);
         check({tag, "_resp"}, 64'(mem_resp), 64'(one));
         if (rd) begin
            check({tag, "_rdata"}, 64'(mem_rdata), 64'(mdl[line][k]));
         end else begin
            mem_wdata[DW*ch +: DW] = wline[DW*k +: DW];
            mdl[line][k]           = wline[DW*k +: DW];
            check({tag, "_wr_rdata"}, 64'(mem_rdata), 64'd0);
         end
      end
   endtask

   task automatic txn(input string tag, input int ch, input bit rd, input bit wr,
                      input logic [31:0] addr, input logic [DW*BL-1:0] wline);
      int lat;
      @(posedge clk); #1;
      set_req(ch, rd, wr, addr);
      lat = model_grant(ch, addr);
      if (rd && wr) err_m = 1'b1;
      serve(tag, ch, line_of(addr), rd, wline, lat + 1);
      @(posedge clk); #1;
      set_req(ch, 1'b0, 1'b0, addr);
      @(negedge clk);
      check({tag, "_turn_resp"}, 64'(mem_resp), 64'd0);
      check({tag, "_turn_busy"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [DW*BL-1:0] line_a, line_w, wl;
      logic [31:0] a;
      int lat, n, c0;
      bit got, rd;

      rst = 1'b1; mem_read = '0; mem_write = '0; mem_addr = '0; mem_wdata = '0;
      for (int i = 0; i < DEPTH; i++) for (int k = 0; k < BL; k++) mdl[i][k] = '0;
      line_a = {64'hD, 64'hC, 64'hB, 64'hA};
      line_w = {64'd4, 64'd3, 64'd2, 64'd1};

      do_reset();
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_resp", 64'(mem_resp), 64'd0);
      check("rst_rdata", 64'(mem_rdata), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      txn("miss_rd", 0, 1'b1, 1'b0, 32'h100, '0);
      txn("wr_1000", 0, 1'b0, 1'b1, 32'h1000, line_a);
      txn("hit_rd", 0, 1'b1, 1'b0, 32'h1000, '0);

      // Both channels request as reset is released.
      set_req(0, 1'b1, 1'b0, 32'h2000);
      set_req(1, 1'b1, 1'b0, 32'h2040);
      do_reset();
      c0  = pick(2'b11);
      lat = model_grant(c0, 32'h2000);
      serve("arb_a0", c0, line_of(32'h2000), 1'b1, '0, lat + 1);
      @(posedge clk); #1; set_req(0, 1'b0, 1'b0, 32'h2000);
      lat = model_grant(1, 32'h2040);
      serve("arb_a1", 1, line_of(32'h2040), 1'b1, '0, lat + 2);
      @(posedge clk); #1; set_req(1, 1'b0, 1'b0, 32'h2040);
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 32'h2000);
      set_req(1, 1'b1, 1'b0, 32'h2040);
      c0  = pick(2'b11);
      lat = model_grant(c0, 32'h2000);
      serve("arb_b0", c0, line_of(32'h2000), 1'b1, '0, lat + 1);
      @(posedge clk); #1; set_req(0, 1'b0, 1'b0, 32'h2000);
      lat = model_grant(1, 32'h2040);
      serve("arb_b1", 1, line_of(32'h2040), 1'b1, '0, lat + 2);
      @(posedge clk); #1; set_req(1, 1'b0, 1'b0, 32'h2040);
      @(negedge clk); @(negedge clk);
      check("arb_idle", 64'(busy), 64'd0);

      txn("wrap_wr", 0, 1'b0, 1'b1, 32'h8000, line_w);
      txn("wrap_rd", 0, 1'b1, 1'b0, 32'h0, '0);

      txn("perr", 1, 1'b1, 1'b1, 32'h0, '0);
      check("perr_sticky", 64'(err), 64'd1);

      // ch0 abandons its request during WAIT.
      @(posedge clk); #1;
      set_req(0, 1'b1, 1'b0, 32'h5000);
      lat = model_grant(0, 32'h5000);
      repeat (10) @(negedge clk);
      check("dropw_noresp", 64'(mem_resp), 64'd0);
      @(posedge clk); #1; set_req(0, 1'b0, 1'b0, 32'h5000);
      @(negedge clk); check("dropw_busy0", 64'(busy), 64'd1);
      @(negedge clk); check("dropw_busy1", 64'(busy), 64'd1);
      check("dropw_resp", 64'(mem_resp), 64'd0);
      @(negedge clk); check("dropw_idle", 64'(busy), 64'd0);
      check("dropw_err", 64'(err), 64'd1);

      do_reset();
      @(negedge clk);
      check("rst2_err", 64'(err), 64'd0);

      // Reset asserted during write beat 2: beats 0-1 land, 2-3 keep old data.
      wl = rand_line();
      @(posedge clk); #1;
      set_req(0, 1'b0, 1'b1, 32'h1000);
      lat = model_grant(0, 32'h1000);
      n = 0; got = 1'b0;
      while (!got && n < 400) begin
         @(negedge clk);
         if (mem_resp[0]) got = 1'b1; else n++;
      end
      check("rstb_latency", 64'(n), 64'(lat + 1));
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         mem_wdata[0 +: DW] = wl[DW*k +: DW];
         if (k < 2) mdl[line_of(32'h1000)][k] = wl[DW*k +: DW];
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      set_req(0, 1'b0, 1'b0, 32'h1000);
      row_v = 1'b0; rr = NCH - 1; err_m = 1'b0;
      @(negedge clk);
      check("rstb_resp", 64'(mem_resp), 64'd0);
      check("rstb_busy", 64'(busy), 64'd0);
      check("rstb_err", 64'(err), 64'd0);
      txn("rstb_rd", 0, 1'b1, 1'b0, 32'h1000, '0);

      // ch1 drops its write request on beat 1.
      wl = rand_line();
      @(posedge clk); #1;
      set_req(1, 1'b0, 1'b1, 32'h3000);
      lat = model_grant(1, 32'h3000);
      n = 0; got = 1'b0;
      while (!got && n < 400) begin
         @(negedge clk);
         if (mem_resp[1]) got = 1'b1; else n++;
      end
      check("dropb_latency", 64'(n), 64'(lat + 1));
      mem_wdata[DW +: DW] = wl[0 +: DW];
      mdl[line_of(32'h3000)][0] = wl[0 +: DW];
      @(negedge clk);
      set_req(1, 1'b0, 1'b0, 32'h3000);
      #1;
      check("dropb_resp", 64'(mem_resp), 64'd0);
      @(negedge clk);
      check("dropb_turn", 64'(busy), 64'd1);
      check("dropb_err", 64'(err), 64'd1);
      err_m = 1'b1;
      @(negedge clk);
      check("dropb_idle", 64'(busy), 64'd0);
      txn("dropb_rd", 0, 1'b1, 1'b0, 32'h3000, '0);

      do_reset();
      for (int t = 0; t < 16; t++) begin
         a = 32'($urandom_range(0, 2) * 32'h1000 + $urandom_range(0, 7) * 32
                 + $urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) a = a + 32'h8000;
         rd = ($urandom_range(0, 1) == 1);
         txn($sformatf("rnd%0d", t), int'($urandom_range(0, NCH - 1)), rd, !rd, a,
             rand_line());
      end
      check("rnd_err", 64'(err), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multi_port_param_memory.md
Name: multi_port_param_memory

Overview:
- Cycle-accurate simulation burst memory that serves NCH requesters through one shared storage array.
- Generalises the single-channel parametrised memory. Adds a configurable burst shape, open-page (row-buffer) latency modelling, round-robin arbitration across channels, address wrap into a finite depth, and protocol-error flagging.
- Sits in the testbench top as the backing memory for split I/D caches or multiple cache ports.

Parameters:
- NCH, 2, number of requester channels (≥1)
- DATA_W, 64, bits per burst beat (multiple of 8)
- BURST_LEN, 4, beats per transaction (≥1)
- DEPTH_LINES, 1024, lines of storage (power of two)
- PAGE_BITS, 12, row = addr[31:PAGE_BITS]
- MISS_CYCLES, 50, wait cycles on row miss (≥ HIT_CYCLES)
- HIT_CYCLES, 25, wait cycles on row hit (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mem_read  in  NCH  per-channel read request, held until the last resp beat
- mem_write  in  NCH  per-channel write request, held until the last resp beat
- mem_addr  in  NCH*32  per-channel byte address; channel i at [32*i+:32]
- mem_wdata  in  NCH*DATA_W  per-channel write beat; channel i at [DATA_W*i+:DATA_W]
- mem_rdata  out  DATA_W  shared read beat; valid only with the granted channel's resp during a read
- mem_resp  out  NCH  per-channel beat strobe
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky protocol-error flag, cleared only by rst

Behaviour:
- Clock and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: mem_resp=0, mem_rdata=0, busy=0, err=0, state=IDLE, open-row valid=0, RR pointer=NCH-1.
  - Storage is not cleared by rst; it is zero at time 0.
- Addressing:
  - LINE_BYTES = DATA_W/8*BURST_LEN.
  - Line = addr[31:log2(LINE_BYTES)]; lower bits are ignored.
  - Storage index = line mod DEPTH_LINES (wrap-around aliasing).
  - Beat k occupies bits [DATA_W*k+:DATA_W] of the line.
- States: IDLE, WAIT, BURST, TURN.
- IDLE:
  - A channel is requesting if read|write is set.
  - Grant the first requesting channel searching from RR pointer+1 modulo NCH.
  - On grant, latch channel, op, line index and row, then set the RR pointer to the granted channel.
  - L = HIT_CYCLES if the open row is valid and equals the new row, else MISS_CYCLES.
  - Update the open row and set valid. Go to WAIT.
- WAIT: count L cycles, then go to BURST.
- Timing, request granted at cycle t:
  - WAIT occupies t+1..t+L.
  - Beats occur at t+L+1..t+L+BURST_LEN, with mem_resp[ch]=1 every beat cycle.
  - TURN at t+L+BURST_LEN+1; the next grant is possible at t+L+BURST_LEN+2 at the earliest.
- Read beat k: mem_rdata = storage beat k, combinational from the beat counter. mem_rdata=0 outside read beats.
- Write beat k: mem_wdata of the granted channel is sampled and committed at the clock edge ending beat cycle k.
- TURN: one cycle with no grant, so requesters can drop their request. Then go to IDLE.
- Both read and write set on one channel at grant: set err; treat as a read.
- Granted channel drops its request before the last beat:
  - Set err, deassert resp, go to TURN.
  - Already-committed write beats remain.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at reset values.
  - The open row is invalidated and partial write beats remain.
- Non-granted channels see mem_resp=0 throughout.

Test Plan:
- Row miss read: after rst, ch0 reads 0x100, granted at t.
  - WAIT t+1..t+50; mem_resp[0] high t+51..t+54 with 4 zero beats.
  - busy low at t+56.
- Write then hit read: ch0 writes 0x1000 with beats 0xA,0xB,0xC,0xD (miss, 50 cycles), then reads 0x1000.
  - Read waits 25 cycles (row 0x1 hit) and returns A,B,C,D in order.
- Arbitration: ch0 and ch1 both request at reset exit.
  - ch0 is served first; ch1 is granted 2 cycles after ch0's last beat.
  - Both re-request: ch0 is served next (pointer=1). mem_resp[1] never asserts during ch0 beats.
- Wrap-around: with LINE_BYTES=32 and DEPTH_LINES=1024, write 0x8000 with beats 1,2,3,4.
  - Read of 0x0 returns 1,2,3,4.
  - 0x8000 and 0x0 are in different rows, so the read pays miss latency.
- Protocol error: ch1 asserts read and write together.
  - err=1 from the grant cycle and stays 1; a read burst is delivered.
  - ch0 drops read in WAIT: err stays 1, FSM reaches IDLE with no resp.
- Reset mid-burst: assert rst during write beat 2.
  - Next cycle mem_resp=0 and busy=0.
  - Beats 0-1 are committed; beats 2-3 are not; the next access pays the miss latency.
